// File: rtl/goruntu_pkg.sv
// Shared image-pipeline constants: pixel width and window-generator FSM encoding.
package goruntu_pkg;
  localparam int PIKSEL_W = 8;

  localparam logic [1:0] BOS      = 2'd0;
  localparam logic [1:0] DOLUM    = 2'd1;
  localparam logic [1:0] AKIS     = 2'd2;
  localparam logic [1:0] BOSALTMA = 2'd3;
endpackage

// File: rtl/satir_tamponu.sv
// Two-line-plus-three pixel shift register; tap k holds window position k (0 = top-left, 8 = bottom-right).
module satir_tamponu
  import goruntu_pkg::*;
#(
  parameter int IMG_W = 128
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    kaydir,
  input  logic [PIKSEL_W-1:0]     giris,
  output logic [9*PIKSEL_W-1:0]   pencere
);
  localparam int DERINLIK = 2 * IMG_W + 3;

  logic [PIKSEL_W-1:0] sr [DERINLIK];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DERINLIK; i++) sr[i] <= '0;
    end else if (kaydir) begin
      sr[0] <= giris;
      for (int i = 1; i < DERINLIK; i++) sr[i] <= sr[i-1];
    end
  end

  // sr[0] is the newest pixel, i.e. the bottom-right neighbour of the centre.
  for (genvar k = 0; k < 9; k++) begin : g_tap
    localparam int DR = k / 3 - 1;
    localparam int DC = k % 3 - 1;
    assign pencere[k*PIKSEL_W +: PIKSEL_W] = sr[(1 - DR) * IMG_W + (1 - DC)];
  end
endmodule

// File: rtl/pencere_uretici.sv
// 3x3 sliding-window generator over a raster pixel stream with valid/ready on both sides.
// Zero padding by default; defining PENCERE_KENAR_KOPYA_EN switches to edge replication.
module pencere_uretici
  import goruntu_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [PIKSEL_W-1:0] piksel_i,
  input  logic                piksel_gecerli_i,
  output logic                hazir_o,
  output logic [PIKSEL_W-1:0] g0_o,
  output logic [PIKSEL_W-1:0] g1_o,
  output logic [PIKSEL_W-1:0] g2_o,
  output logic [PIKSEL_W-1:0] g3_o,
  output logic [PIKSEL_W-1:0] g4_o,
  output logic [PIKSEL_W-1:0] g5_o,
  output logic [PIKSEL_W-1:0] g6_o,
  output logic [PIKSEL_W-1:0] g7_o,
  output logic [PIKSEL_W-1:0] g8_o,
  output logic                pencere_gecerli_o,
  input  logic                hazir_i,
  output logic                cerceve_bitti_o
);
  localparam int N  = IMG_W * IMG_H;
  localparam int KW = $clog2(N + 1);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [KW-1:0] K_AKIS = KW'(IMG_W + 1);
  localparam logic [KW-1:0] K_SON  = KW'(N - 1);

  logic [1:0]            durum;
  logic [KW-1:0]         k_say;
  logic [RW-1:0]         satir;
  logic [CW-1:0]         sutun;
  logic                  gecerli, bitti;
  logic                  pix_al, pen_al, son, kaydir, ilerle;
  logic                  ust, alt, sol, sag;
  logic [PIKSEL_W-1:0]   giris;
  logic [9*PIKSEL_W-1:0] pencere;
  logic [PIKSEL_W-1:0]   tap [9];
  logic [PIKSEL_W-1:0]   g   [9];

  assign son     = (satir == RW'(IMG_H - 1)) && (sutun == CW'(IMG_W - 1));
  assign hazir_o = en_i && ((durum == BOS) || (durum == DOLUM) ||
                            ((durum == AKIS) && (!gecerli || hazir_i)));
  assign pix_al  = piksel_gecerli_i && hazir_o;
  assign pen_al  = gecerli && hazir_i;
  // While draining, padding is shifted in so the last IMG_W+1 centres reach the taps.
  assign kaydir  = pix_al || ((durum == BOSALTMA) && pen_al && !son);
  assign ilerle  = kaydir && ((durum == AKIS) || (durum == BOSALTMA));
  assign giris   = pix_al ? piksel_i : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum   <= BOS;
      k_say   <= '0;
      satir   <= '0;
      sutun   <= '0;
      gecerli <= 1'b0;
      bitti   <= 1'b0;
    end else if (!en_i) begin
      durum   <= BOS;
      k_say   <= '0;
      satir   <= '0;
      sutun   <= '0;
      gecerli <= 1'b0;
      bitti   <= 1'b0;
    end else begin
      bitti <= 1'b0;
      if (pix_al) k_say <= k_say + 1'b1;
      if (ilerle) begin
        if (sutun == CW'(IMG_W - 1)) begin
          sutun <= '0;
          satir <= satir + 1'b1;
        end else begin
          sutun <= sutun + 1'b1;
        end
      end
      case (durum)
        BOS: if (pix_al) durum <= DOLUM;
        DOLUM: if (pix_al && (k_say == K_AKIS)) begin
          durum   <= AKIS;
          gecerli <= 1'b1;
        end
        AKIS: begin
          // A consumed window with no new pixel leaves the taps on the old centre.
          if (pix_al) gecerli <= 1'b1;
          else if (hazir_i) gecerli <= 1'b0;
          if (pix_al && (k_say == K_SON)) durum <= BOSALTMA;
        end
        BOSALTMA: if (pen_al && son) begin
          durum   <= BOS;
          gecerli <= 1'b0;
          bitti   <= 1'b1;
          k_say   <= '0;
          satir   <= '0;
          sutun   <= '0;
        end
        default: durum <= BOS;
      endcase
    end
  end

  satir_tamponu #(.IMG_W(IMG_W)) u_tampon (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .kaydir  (kaydir),
    .giris   (giris),
    .pencere (pencere)
  );

  assign ust = (satir == '0);
  assign alt = (satir == RW'(IMG_H - 1));
  assign sol = (sutun == '0);
  assign sag = (sutun == CW'(IMG_W - 1));

  for (genvar k = 0; k < 9; k++) begin : g_pen
    localparam int DR    = k / 3 - 1;
    localparam int DC    = k % 3 - 1;
    localparam int K_SAT = 3 + DC + 1;
    localparam int K_SUT = (DR + 1) * 3 + 1;
    logic satir_dis, sutun_dis;
    assign tap[k]    = pencere[k*PIKSEL_W +: PIKSEL_W];
    assign satir_dis = ((DR == -1) && ust) || ((DR == 1) && alt);
    assign sutun_dis = ((DC == -1) && sol) || ((DC == 1) && sag);
`ifdef PENCERE_KENAR_KOPYA_EN
    assign g[k] = (satir_dis && sutun_dis) ? tap[4] :
                  satir_dis ? tap[K_SAT] :
                  sutun_dis ? tap[K_SUT] : tap[k];
`else
    assign g[k] = (satir_dis || sutun_dis) ? '0 : tap[k];
`endif
  end

  assign g0_o = g[0];
  assign g1_o = g[1];
  assign g2_o = g[2];
  assign g3_o = g[3];
  assign g4_o = g[4];
  assign g5_o = g[5];
  assign g6_o = g[6];
  assign g7_o = g[7];
  assign g8_o = g[8];
  assign pencere_gecerli_o = gecerli;
  assign cerceve_bitti_o   = bitti;
endmodule

// File: tb/tb_pencere_uretici.sv
// Randomized bench for pencere_uretici (4x4 image) against a frame-array window model.
module tb_pencere_uretici;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk_i = 1'b0;
  logic       rst_ni, en_i, piksel_gecerli_i, hazir_i;
  logic [7:0] piksel_i;
  logic       hazir_o, pencere_gecerli_o, cerceve_bitti_o;
  logic [7:0] g0_o, g1_o, g2_o, g3_o, g4_o, g5_o, g6_o, g7_o, g8_o;

  always #5 clk_i = ~clk_i;

  pencere_uretici #(.IMG_W(W), .IMG_H(H)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
    .piksel_i(piksel_i), .piksel_gecerli_i(piksel_gecerli_i), .hazir_o(hazir_o),
    .g0_o(g0_o), .g1_o(g1_o), .g2_o(g2_o), .g3_o(g3_o), .g4_o(g4_o),
    .g5_o(g5_o), .g6_o(g6_o), .g7_o(g7_o), .g8_o(g8_o),
    .pencere_gecerli_o(pencere_gecerli_o), .hazir_i(hazir_i),
    .cerceve_bitti_o(cerceve_bitti_o)
  );

  int n_kontrol = 0;
  int n_gecen   = 0;

  task automatic kontrol(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_kontrol++;
    if (got === exp) n_gecen++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  logic [7:0]  img [0:3][0:N-1];
  logic [71:0] cap [0:N-1];
  logic [71:0] cap1_0;
  int kp, pf, nw, wf;

  function automatic logic [71:0] gozlem();
    return {g0_o, g1_o, g2_o, g3_o, g4_o, g5_o, g6_o, g7_o, g8_o};
  endfunction

  function automatic logic [71:0] bekl(input int f, input int n);
    logic [71:0] w;
    int r, c;
    w = '0;
    r = n / W;
    c = n % W;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int rr, cc;
        logic [7:0] v;
        rr = r + dr;
        cc = c + dc;
`ifdef PENCERE_KENAR_KOPYA_EN
        if (rr < 0) rr = 0;
        if (rr >= H) rr = H - 1;
        if (cc < 0) cc = 0;
        if (cc >= W) cc = W - 1;
        v = img[f][rr*W + cc];
`else
        if (rr < 0 || rr >= H || cc < 0 || cc >= W) v = 8'd0;
        else v = img[f][rr*W + cc];
`endif
        w[(8 - ((dr + 1) * 3 + (dc + 1))) * 8 +: 8] = v;
      end
    end
    return w;
  endfunction

  task automatic doldur(input int f, input int mod);
    for (int i = 0; i < N; i++)
      img[f][i] = (mod == 0) ? 8'(i + 1) : (mod == 1) ? 8'd255 : 8'($urandom);
  endtask

  task automatic sifirla();
    kp = 0; pf = 0; nw = 0; wf = 0;
  endtask

  // Streams nfr frames; dur_kp / dur_nw stop the run early (-1 = never).
  task automatic kos(input int nfr, input bit rv, input bit rr, input int stall_at,
                     input int dur_kp, input int dur_nw);
    int  say;
    int  stall_left;
    bit  stall_done, bitti_exp, pa, wa;
    say = 0; stall_left = 0; stall_done = 0; bitti_exp = 0;
    while (wf < nfr) begin
      @(negedge clk_i);
      if (say++ > 4000) begin
        kontrol("zaman_asimi", 72'(wf), 72'(nfr));
        return;
      end
      piksel_gecerli_i = (pf < nfr) && (rv ? ($urandom_range(0, 3) != 0) : 1'b1);
      piksel_i = (pf < nfr) ? img[pf][kp] : 8'($urandom);
      if (stall_at >= 0 && !stall_done && wf == 0 && nw == stall_at && pencere_gecerli_o) begin
        stall_left = 3;
        stall_done = 1;
      end
      hazir_i = (stall_left > 0) ? 1'b0 : (rr ? ($urandom_range(0, 2) != 0) : 1'b1);
      #1;
      if (pencere_gecerli_o) kontrol("pencere", gozlem(), bekl(wf, nw));
      if (!(pf > wf || kp >= nw + W + 2)) kontrol("erken_pencere", 72'(pencere_gecerli_o), 72'd0);
      if (pf > wf) kontrol("bosaltma_hazir", 72'(hazir_o), 72'd0);
      else if (kp < W + 2) kontrol("dolum_hazir", 72'(hazir_o), 72'd1);
      else kontrol("akis_hazir", 72'(hazir_o), 72'(!pencere_gecerli_o || hazir_i));
      if (stall_left > 0 && pencere_gecerli_o) kontrol("durak_hazir", 72'(hazir_o), 72'd0);
      if (bitti_exp || cerceve_bitti_o) kontrol("cerceve_bitti", 72'(cerceve_bitti_o), 72'(bitti_exp));
      if (stall_left > 0) stall_left--;
      pa = piksel_gecerli_i && hazir_o;
      wa = pencere_gecerli_o && hazir_i;
      bitti_exp = 0;
      if (wa) begin
        if (wf == 0) cap[nw] = gozlem();
        if (wf == 1 && nw == 0) cap1_0 = gozlem();
        nw++;
        if (nw == N) begin nw = 0; wf++; bitti_exp = 1; end
      end
      if (pa) begin
        kp++;
        if (kp == N) begin kp = 0; pf++; end
      end
      if (dur_kp >= 0 && pf == 0 && kp == dur_kp) return;
      if (dur_nw >= 0 && wf == 0 && nw == dur_nw) return;
    end
    @(negedge clk_i);
    piksel_gecerli_i = 1'b0;
    hazir_i = 1'b1;
    #1;
    kontrol("cerceve_bitti_son", 72'(cerceve_bitti_o), 72'(bitti_exp));
    kontrol("fazla_pencere", 72'(pencere_gecerli_o), 72'd0);
    @(negedge clk_i);
    #1;
    kontrol("bitti_tek_darbe", 72'(cerceve_bitti_o), 72'd0);
  endtask

  logic [71:0] w0_bek, w5_bek, w0_255, hep255;

  initial begin
`ifdef PENCERE_KENAR_KOPYA_EN
    w0_bek = {8'd1, 8'd1, 8'd2, 8'd1, 8'd1, 8'd2, 8'd5, 8'd5, 8'd6};
    w0_255 = {9{8'd255}};
`else
    w0_bek = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd5, 8'd6};
    w0_255 = {8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255};
`endif
    w5_bek = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
    hep255 = {9{8'd255}};

    rst_ni = 1'b0; en_i = 1'b1; piksel_gecerli_i = 1'b0; piksel_i = '0; hazir_i = 1'b1;
    repeat (3) @(negedge clk_i);
    kontrol("reset_gecerli", 72'(pencere_gecerli_o), 72'd0);
    kontrol("reset_bitti", 72'(cerceve_bitti_o), 72'd0);
    kontrol("reset_pencere", gozlem(), 72'd0);
    rst_ni = 1'b1;
    #1;
    kontrol("reset_sonrasi_hazir", 72'(hazir_o), 72'd1);

    // Basic frame, pixel = index + 1
    doldur(0, 0); sifirla();
    kos(1, 0, 0, -1, -1, -1);
    kontrol("cerceve1_w0", cap[0], w0_bek);
    kontrol("cerceve1_w5", cap[5], w5_bek);

    // Downstream stall of three cycles on window 7
    sifirla();
    kos(1, 0, 0, 7, -1, -1);
    kontrol("durak_w7", cap[7], bekl(0, 7));

    // All-255 frame
    doldur(0, 1); sifirla();
    kos(1, 0, 0, -1, -1, -1);
    kontrol("beyaz_w0", cap[0], w0_255);
    kontrol("beyaz_w5", cap[5], hep255);

    // Asynchronous reset mid-frame, then a clean frame
    doldur(0, 0); sifirla();
    kos(1, 0, 0, -1, 9, -1);
    @(negedge clk_i);
    piksel_gecerli_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    kontrol("asenk_reset_gecerli", 72'(pencere_gecerli_o), 72'd0);
    kontrol("asenk_reset_pencere", gozlem(), 72'd0);
    kontrol("asenk_reset_bitti", 72'(cerceve_bitti_o), 72'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    kontrol("asenk_reset_hazir", 72'(hazir_o), 72'd1);
    sifirla();
    kos(1, 0, 0, -1, -1, -1);
    kontrol("reset_sonra_w0", cap[0], w0_bek);
    kontrol("reset_sonra_w5", cap[5], w5_bek);

    // Synchronous clear via en_i after window 3
    sifirla();
    kos(1, 0, 0, -1, -1, 4);
    @(negedge clk_i);
    en_i = 1'b0;
    piksel_gecerli_i = 1'b0;
    @(negedge clk_i);
    en_i = 1'b1;
    #1;
    kontrol("en_temiz_gecerli", 72'(pencere_gecerli_o), 72'd0);
    kontrol("en_temiz_hazir", 72'(hazir_o), 72'd1);
    kontrol("en_temiz_bitti", 72'(cerceve_bitti_o), 72'd0);
    sifirla();
    kos(1, 0, 0, -1, -1, -1);
    kontrol("en_sonra_w0", cap[0], w0_bek);
    kontrol("en_sonra_w5", cap[5], w5_bek);

    // Two frames back to back
    doldur(0, 0); doldur(1, 0); sifirla();
    kos(2, 0, 0, -1, -1, -1);
    kontrol("arka_arkaya_w16", cap1_0, w0_bek);

    // Random pixels with random valid/ready on both sides
    for (int t = 0; t < 4; t++) begin
      doldur(0, 2); doldur(1, 2); doldur(2, 2); sifirla();
      kos(3, 1, 1, (t == 1) ? 5 : -1, -1, -1);
    end

    $display("%0d/%0d checks passed", n_gecen, n_kontrol);
    $finish;
  end
endmodule

// File: doc/pencere_uretici.md
PENCERE_URETICI -- requirements
Module: pencere_uretici

Interface
REQ-001 SHALL have parameter IMG_W, default 128, image width in pixels (min 3).
REQ-002 SHALL have parameter IMG_H, default 128, image height in pixels (min 3).
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en_i  input  1  block enable; low = synchronous clear.
REQ-006 SHALL have port piksel_i  input  8  raster-order input pixel.
REQ-007 SHALL have port piksel_gecerli_i  input  1  piksel_i valid.
REQ-008 SHALL have port hazir_o  output  1  block accepts piksel_i this cycle.
REQ-009 SHALL have ports g0_o..g8_o  output  8 each  3x3 window, row-major, g0 top-left, g4 centre, g8 bottom-right.
REQ-010 SHALL have port pencere_gecerli_o  output  1  window valid.
REQ-011 SHALL have port hazir_i  input  1  downstream (erosion stage) accepts window.
REQ-012 SHALL have port cerceve_bitti_o  output  1  one-cycle pulse, last window of frame accepted.

Function
REQ-013 SHALL accept a pixel when piksel_gecerli_i && hazir_o; K = accepted-pixel count (0..IMG_W*IMG_H).
REQ-014 SHALL emit exactly IMG_W*IMG_H windows per frame, raster order of centre n = r*IMG_W + c.
REQ-015 SHALL make window n emittable once K >= min(n + IMG_W + 2, IMG_W*IMG_H).
REQ-016 SHALL use FSM BOS -> DOLUM (first pixel accepted) -> AKIS (K = IMG_W+2) -> BOSALTMA (K = IMG_W*IMG_H) -> BOS (last window accepted).
REQ-017 SHALL, in BOS/DOLUM, hold hazir_o = 1 and pencere_gecerli_o = 0.
REQ-018 SHALL, in AKIS, set hazir_o = !pencere_gecerli_o || hazir_i; each accepted pixel produces one window.
REQ-019 SHALL, in BOSALTMA, hold hazir_o = 0 and emit remaining IMG_W+1 windows, shifting padding internally.
REQ-020 SHALL hold g0_o..g8_o stable while pencere_gecerli_o = 1 && hazir_i = 0.
REQ-021 SHALL replace window positions outside the image (row -1, row IMG_H, col -1, col IMG_W) with 0.
REQ-022 SHALL track centre row/column counters that wrap col IMG_W-1 -> 0 with row increment.
REQ-023 SHALL pulse cerceve_bitti_o in the cycle after window IMG_W*IMG_H-1 is accepted, returning to BOS.
REQ-024 SHALL ignore piksel_gecerli_i while hazir_o = 0 (no implicit buffering).
REQ-025 SHALL, when en_i = 0, next edge: state BOS, counters 0, pencere_gecerli_o 0, cerceve_bitti_o 0; line storage contents irrelevant.
REQ-026 SHALL permit back-to-back frames: first pixel of next frame accepted the cycle after returning to BOS.

Reset
REQ-027 SHALL, on rst_ni = 0, asynchronously set state BOS, K, row/col counters 0, pencere_gecerli_o 0, cerceve_bitti_o 0, g0_o..g8_o 0.
REQ-028 SHALL, after rst_ni deassertion mid-frame, restart at pixel 0 of a new frame; hazir_o = 1 in first cycle.

Configuration
REQ-029 SHALL, with PENCERE_KENAR_KOPYA_EN defined, replace out-of-image positions with nearest in-image pixel (edge replicate) instead of 0.
REQ-030 SHALL, without PENCERE_KENAR_KOPYA_EN, use zero padding per REQ-021; ports unchanged in both builds.

Structure
REQ-031 SHALL place FSM state encoding (BOS, DOLUM, AKIS, BOSALTMA) and pixel width constant 8 in shared package goruntu_pkg.
REQ-032 SHALL implement pixel storage as sub-module satir_tamponu: a 2*IMG_W+3 deep, 8-bit shift register with shift enable and 9 window taps.

Verification (IMG_W=4, IMG_H=4, pixel value = index+1, hazir_i = 1)
REQ-033 Frame 1..16 -> 16 windows; window 0 = {0,0,0,0,1,2,0,5,6}; window 5 = {1,2,3,5,6,7,9,10,11}; cerceve_bitti_o one pulse.
REQ-034 Same frame, hazir_i low 3 cycles at window 7 -> window 7 held stable, hazir_o 0 during stall, no pixel lost.
REQ-035 All pixels 255 -> interior windows all 255; window 0 = {0,0,0,0,255,255,0,255,255}; with KOPYA_EN all nine 255.
REQ-036 rst_ni low after pixel 9 -> outputs 0 immediately; new frame 1..16 after release gives REQ-033 windows.
REQ-037 en_i low one cycle after window 3 -> state BOS, pencere_gecerli_o 0; restarted frame reproduces REQ-033.
REQ-038 Two frames back-to-back, piksel_gecerli_i constantly 1 -> 32 windows, two cerceve_bitti_o pulses, window 16 = window 0 pattern of frame 2.
